mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-002 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port op, input, 7, opcode field instr[6:0] from the instruction register.
REQ-004 SHALL have port Zero, input, 1, ALU zero flag.
REQ-005 SHALL have port MemReady, input, 1, memory access complete this cycle.
REQ-006 SHALL have outputs PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, each 1 bit, and ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, each 2 bits, as datapath controls.
REQ-007 SHALL have port IllegalOp, output, 1, unrecognised opcode detected.
REQ-008 ALUOp SHALL use this encoding toward the downstream ALU decoder: 00 add, 01 subtract (branch compare), 10 decode from funct3/funct7.

Function
REQ-009 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL; state register updates on rising clk.
REQ-010 Transitions: FETCH->DECODE on MemReady=1, else hold; MEMREAD->MEMWB on MemReady=1, else hold; MEMWRITE->FETCH on MemReady=1, else hold.
REQ-011 DECODE SHALL go to MEMADR for op 0000011/0100011, EXECUTER for 0110011, EXECUTEI for 0010011, BEQ for 1100011, JAL for 1101111, and FETCH for any other op.
REQ-012 MEMADR SHALL go to MEMREAD if op=0000011, else MEMWRITE; MEMWB, ALUWB and BEQ ->FETCH; EXECUTER, EXECUTEI and JAL ->ALUWB.
REQ-013 Outputs per state; unlisted signals are 0.
- FETCH: IRWrite=MemReady, ALUSrcB=10, ResultSrc=10, PCUpdate=MemReady.
- DECODE: ALUSrcA=01, ALUSrcB=01.
- MEMADR: ALUSrcA=10, ALUSrcB=01.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1.
- EXECUTER: ALUSrcA=10, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: RegWrite=1.
- BEQ: ALUSrcA=10, ALUOp=01, Branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
REQ-014 PCWrite SHALL equal PCUpdate OR (Branch AND Zero), combinationally.
REQ-015 ImmSrc SHALL be decoded combinationally from op in every state: 0100011->01, 1100011->10, 1101111->11, all others->00.
REQ-016 IllegalOp SHALL be 1 only while in DECODE with an op not listed in REQ-011, giving a one-cycle pulse.
REQ-017 A stalled FETCH or MEMREAD (MemReady=0) SHALL assert no write strobe; a stalled MEMWRITE SHALL hold MemWrite=1 with AdrSrc=1 until MemReady=1.
REQ-018 Instruction latency without stalls SHALL be: lw 5 cycles, sw 4, R/I-type 4, beq 3, jal 4.

Reset
REQ-019 resetn=0 SHALL immediately force state to FETCH, asynchronously.
REQ-020 While resetn=0, PCWrite, IRWrite, MemWrite and RegWrite SHALL be 0 regardless of MemReady, and IllegalOp SHALL be 0.
REQ-021 Reset asserted mid-instruction SHALL abandon that instruction; after release, the first edge with MemReady=1 advances FETCH->DECODE.

Structure
REQ-022 State encoding, ALUOp codes and opcode constants SHALL live in the shared CPU package; no literal opcodes in the FSM body.
REQ-023 The ImmSrc decode SHALL be a separate combinational sub-module, immdec; the FSM stays in mc_controller.

Verification
REQ-024 lw (op 0000011), MemReady=1 throughout -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH; RegWrite=1 only in MEMWB with ResultSrc=01.
REQ-025 sw (op 0100011), MemReady=0 for 2 cycles in MEMWRITE -> MemWrite=1 for 3 cycles, ImmSrc=01, then FETCH.
REQ-026 beq (op 1100011): with Zero=1 -> PCWrite=1 in BEQ; with Zero=0 -> PCWrite=0; both ALUOp=01.
REQ-027 op 0000000 -> IllegalOp=1 for exactly one cycle in DECODE, next state FETCH, no write strobes.
REQ-028 FETCH with MemReady=0 for 3 cycles -> IRWrite=0 and PCWrite=0; on the 4th cycle with MemReady=1 -> IRWrite=1 and PCWrite=1 for one cycle.
REQ-029 resetn pulsed low during EXECUTER (add, op 0110011) -> state FETCH before the next edge, RegWrite never asserted for that instruction.

Source files
------------

// File: rtl/mc_controller_pkg.sv
// Shared CPU definitions for the multicycle controller: FSM states, ALU op
// codes, immediate formats and the opcode constants the decoder recognises.
package mc_controller_pkg;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MEMADR,
    ST_MEMREAD,
    ST_MEMWB,
    ST_MEMWRITE,
    ST_EXECUTER,
    ST_EXECUTEI,
    ST_ALUWB,
    ST_BEQ,
    ST_JAL
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } immsrc_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  function automatic logic is_known_op(input logic [6:0] op);
    return (op == OP_LOAD)  || (op == OP_STORE)  || (op == OP_RTYPE) ||
           (op == OP_ITYPE) || (op == OP_BRANCH) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/mc_controller_immdec.sv
// Immediate-format decode from the opcode; purely combinational, independent
// of controller state.
module immdec
  import mc_controller_pkg::*;
(
  input  logic [6:0] op_i,
  output logic [1:0] imm_src_o
);

  immsrc_e imm_src;

  always_comb begin
    imm_src = IMM_I;
    case (op_i)
      OP_STORE:  imm_src = IMM_S;
      OP_BRANCH: imm_src = IMM_B;
      OP_JAL:    imm_src = IMM_J;
      default:   imm_src = IMM_I;
    endcase
  end

  assign imm_src_o = imm_src;

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V main controller: Moore FSM sequencing fetch, decode,
// memory, execute and writeback, plus branch-qualified PC write.
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       IllegalOp
);

  state_e state_q, state_d;

  logic   pc_update, branch, mem_write, ir_write, reg_write;
  aluop_e alu_op;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_FETCH;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:    if (MemReady) state_d = ST_DECODE;
      ST_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = ST_MEMADR;
          OP_RTYPE:          state_d = ST_EXECUTER;
          OP_ITYPE:          state_d = ST_EXECUTEI;
          OP_BRANCH:         state_d = ST_BEQ;
          OP_JAL:            state_d = ST_JAL;
          default:           state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR:   state_d = (op == OP_LOAD) ? ST_MEMREAD : ST_MEMWRITE;
      ST_MEMREAD:  if (MemReady) state_d = ST_MEMWB;
      ST_MEMWRITE: if (MemReady) state_d = ST_FETCH;
      ST_EXECUTER, ST_EXECUTEI, ST_JAL: state_d = ST_ALUWB;
      default:     state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    pc_update = 1'b0;
    branch    = 1'b0;
    AdrSrc    = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    ResultSrc = '0;
    ALUSrcA   = '0;
    ALUSrcB   = '0;
    alu_op    = ALUOP_ADD;
    case (state_q)
      ST_FETCH: begin
        ir_write  = MemReady;
        pc_update = MemReady;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      ST_DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
      ST_MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      ST_MEMREAD:  AdrSrc = 1'b1;
      ST_MEMWB:    begin ResultSrc = 2'b01; reg_write = 1'b1; end
      ST_MEMWRITE: begin AdrSrc = 1'b1; mem_write = 1'b1; end
      ST_EXECUTER: begin ALUSrcA = 2'b10; alu_op = ALUOP_FUNCT; end
      ST_EXECUTEI: begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; alu_op = ALUOP_FUNCT; end
      ST_ALUWB:    reg_write = 1'b1;
      ST_BEQ:      begin ALUSrcA = 2'b10; alu_op = ALUOP_SUB; branch = 1'b1; end
      ST_JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; pc_update = 1'b1; end
      default: ;
    endcase
  end

  // Strobes are gated by resetn directly so they stay low for the whole
  // reset pulse, even though FETCH would otherwise follow MemReady.
  assign PCWrite   = resetn & (pc_update | (branch & Zero));
  assign IRWrite   = resetn & ir_write;
  assign MemWrite  = resetn & mem_write;
  assign RegWrite  = resetn & reg_write;
  assign IllegalOp = resetn & (state_q == ST_DECODE) & ~is_known_op(op);
  assign ALUOp     = alu_op;

  immdec u_immdec (
    .op_i      (op),
    .imm_src_o (ImmSrc)
  );

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: an instruction-sequence model predicts
// every control output each cycle; literal counts pin latencies and strobes.
module tb_mc_controller;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] BAD = 7'b0000000;

  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3,
                 P_MEMWB = 4, P_MEMWRITE = 5, P_EXR = 6, P_EXI = 7,
                 P_ALUWB = 8, P_BEQ = 9, P_JAL = 10;

  logic       clk = 1'b0;
  logic       resetn, Zero, MemReady;
  logic [6:0] op;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalOp;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk       (clk),
    .resetn    (resetn),
    .op        (op),
    .Zero      (Zero),
    .MemReady  (MemReady),
    .PCWrite   (PCWrite),
    .AdrSrc    (AdrSrc),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .RegWrite  (RegWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .ImmSrc    (ImmSrc),
    .IllegalOp (IllegalOp)
  );

  int   n_pass = 0;
  int   n_checks = 0;
  int   phase = P_FETCH;
  int   rest[$];
  logic post_fetch;
  int   cnt_irw, cnt_pcw, cnt_mw, cnt_rw, cnt_ill, cnt_sub, cnt_memwb_rw;
  logic [1:0] last_imm;

  wire [15:0] dut_ctrl = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                          ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, IllegalOp};

  // Control word for a phase: written as a per-phase table of the listed
  // signals, everything unlisted left at zero.
  function automatic logic [15:0] expect_ctrl(input int ph, input logic mr,
      input logic z, input logic [6:0] o, input logic rn);
    logic pcu, br, adr, mw, irw, rw, ill;
    logic [1:0] rs, sa, sb, aop, imm;
    {pcu, br, adr, mw, irw, rw, ill} = '0;
    {rs, sa, sb, aop} = '0;
    case (ph)
      P_FETCH:    begin irw = mr; pcu = mr; sb = 2'b10; rs = 2'b10; end
      P_DECODE:   begin sa = 2'b01; sb = 2'b01; end
      P_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
      P_MEMREAD:  adr = 1'b1;
      P_MEMWB:    begin rs = 2'b01; rw = 1'b1; end
      P_MEMWRITE: begin adr = 1'b1; mw = 1'b1; end
      P_EXR:      begin sa = 2'b10; aop = 2'b10; end
      P_EXI:      begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
      P_ALUWB:    rw = 1'b1;
      P_BEQ:      begin sa = 2'b10; aop = 2'b01; br = 1'b1; end
      P_JAL:      begin sa = 2'b01; sb = 2'b10; pcu = 1'b1; end
      default: ;
    endcase
    imm = (o == SW) ? 2'b01 : (o == BEQ) ? 2'b10 : (o == JAL) ? 2'b11 : 2'b00;
    ill = (ph == P_DECODE) && !(o inside {LW, SW, RT, IT, BEQ, JAL});
    if (!rn) {pcu, br, irw, mw, rw, ill} = '0;
    return {pcu | (br & z), adr, mw, irw, rw, rs, sa, sb, aop, imm, ill};
  endfunction

  task automatic check_ctrl(input string tag);
    logic [15:0] exp_v;
    exp_v = expect_ctrl(phase, MemReady, Zero, op, resetn);
    n_checks++;
    if (dut_ctrl === exp_v) n_pass++;
    else $display("FAIL %s: ctrl got %b want %b (model phase %0d, op %b)",
                  tag, dut_ctrl, exp_v, phase, op);
  endtask

  task automatic check_lit(input string name, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, got, want);
  endtask

  // Instruction-level model: DECODE expands the opcode into its remaining
  // phase list; memory phases wait for MemReady.
  task automatic model_advance();
    if (!resetn) begin
      phase = P_FETCH;
      rest.delete();
    end else if ((phase == P_FETCH || phase == P_MEMREAD || phase == P_MEMWRITE) && !MemReady) begin
      phase = phase;
    end else if (phase == P_FETCH) begin
      phase = P_DECODE;
    end else begin
      if (phase == P_DECODE) begin
        rest.delete();
        case (op)
          LW:  begin rest.push_back(P_MEMADR); rest.push_back(P_MEMREAD); rest.push_back(P_MEMWB); end
          SW:  begin rest.push_back(P_MEMADR); rest.push_back(P_MEMWRITE); end
          RT:  begin rest.push_back(P_EXR); rest.push_back(P_ALUWB); end
          IT:  begin rest.push_back(P_EXI); rest.push_back(P_ALUWB); end
          BEQ: rest.push_back(P_BEQ);
          JAL: begin rest.push_back(P_JAL); rest.push_back(P_ALUWB); end
          default: ;
        endcase
      end
      if (rest.size() > 0) phase = rest.pop_front();
      else                 phase = P_FETCH;
    end
  endtask

  task automatic clear_counts();
    {cnt_irw, cnt_pcw, cnt_mw, cnt_rw, cnt_ill, cnt_sub, cnt_memwb_rw} = '0;
  endtask

  task automatic step(input logic [6:0] o, input logic mr, input logic z);
    op = o; MemReady = mr; Zero = z;
    @(negedge clk);
    check_ctrl("cycle");
    cnt_irw += int'(IRWrite);
    cnt_pcw += int'(PCWrite);
    cnt_mw  += int'(MemWrite);
    cnt_rw  += int'(RegWrite);
    cnt_ill += int'(IllegalOp);
    cnt_sub += int'(ALUOp == 2'b01);
    cnt_memwb_rw += int'(RegWrite && ResultSrc == 2'b01);
    last_imm = ImmSrc;
    @(posedge clk);
    model_advance();
    #1;
    post_fetch = (ALUSrcB == 2'b10) && (ResultSrc == 2'b10);
  endtask

  task automatic run_instr(input logic [6:0] o, input logic z, input int exp_lat,
                           input string name);
    int c;
    step(o, 1'b1, z);
    c = 1;
    while (!post_fetch && c < 20) begin
      step(o, 1'b1, z);
      c++;
    end
    check_lit({name, " latency"}, c, exp_lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; op = LW; MemReady = 1'b1; Zero = 1'b0;
    #2;
    clear_counts();
    step(LW, 1'b1, 1'b0);
    step(LW, 1'b1, 1'b1);
    check_lit("strobes during reset", cnt_irw + cnt_pcw + cnt_mw + cnt_rw, 0);
    resetn = 1'b1;
    #1;
    check_lit("reset state is fetch", int'(post_fetch), 1);

    clear_counts();
    run_instr(LW, 1'b0, 5, "lw");
    check_lit("lw RegWrite cycles", cnt_rw, 1);
    check_lit("lw RegWrite with ResultSrc=01", cnt_memwb_rw, 1);

    clear_counts();
    step(SW, 1'b1, 1'b0);
    step(SW, 1'b1, 1'b0);
    step(SW, 1'b1, 1'b0);
    step(SW, 1'b0, 1'b0);
    step(SW, 1'b0, 1'b0);
    step(SW, 1'b1, 1'b0);
    check_lit("sw stalled MemWrite cycles", cnt_mw, 3);
    check_lit("sw ImmSrc", int'(last_imm), 1);
    check_lit("sw returns to fetch", int'(post_fetch), 1);

    run_instr(RT, 1'b0, 4, "rtype");
    run_instr(IT, 1'b0, 4, "itype");
    clear_counts();
    run_instr(JAL, 1'b0, 4, "jal");
    check_lit("jal PCWrite cycles", cnt_pcw, 2);
    check_lit("jal ImmSrc", int'(last_imm), 3);

    clear_counts();
    run_instr(BEQ, 1'b1, 3, "beq taken");
    check_lit("beq taken PCWrite cycles", cnt_pcw, 2);
    check_lit("beq taken ALUOp=01 cycles", cnt_sub, 1);
    clear_counts();
    run_instr(BEQ, 1'b0, 3, "beq not taken");
    check_lit("beq not taken PCWrite cycles", cnt_pcw, 1);
    check_lit("beq not taken ALUOp=01 cycles", cnt_sub, 1);

    clear_counts();
    run_instr(BAD, 1'b0, 2, "illegal");
    check_lit("illegal pulse cycles", cnt_ill, 1);
    check_lit("illegal write strobes", cnt_rw + cnt_mw, 0);

    clear_counts();
    step(RT, 1'b0, 1'b0);
    step(RT, 1'b0, 1'b0);
    step(RT, 1'b0, 1'b0);
    check_lit("stalled fetch IRWrite+PCWrite", cnt_irw + cnt_pcw, 0);
    step(RT, 1'b1, 1'b0);
    check_lit("fetch release IRWrite", cnt_irw, 1);
    check_lit("fetch release PCWrite", cnt_pcw, 1);

    step(RT, 1'b1, 1'b0);
    clear_counts();
    #1;
    resetn = 1'b0;
    phase = P_FETCH;
    rest.delete();
    #1;
    check_ctrl("async reset in execute");
    check_lit("async reset to fetch", int'((ALUSrcB == 2'b10) && (ResultSrc == 2'b10)), 1);
    step(RT, 1'b1, 1'b0);
    resetn = 1'b1;
    check_lit("abandoned RegWrite", cnt_rw, 0);
    clear_counts();
    run_instr(RT, 1'b0, 4, "rtype after reset");
    check_lit("rtype after reset RegWrite", cnt_rw, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
